stickman_motion: RTL and testbench

Vertical-motion and collision controller for the stickman, and the consumer of the ground-height interface. Each frame it samples `GroundY` (terrain height under the stickman's fixed X column) and the jump key, then advances a run/jump/fall state machine with gravity. It outputs the stickman's feet Y for the color mapper and a `game_over` flag for the top-level game FSM.

---
 rtl/stickman_motion.sv | 209 ++++++++++++++++++++
 tb/tb_stickman_motion.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stickman_motion.sv
// stickman_motion
// Vertical motion and collision controller for the stickman. On each frame
// tick it samples the terrain height under the stickman's column and the
// latched jump request. It then advances an IDLE/RUN/AIR/DEAD state machine
// with gravity. All outputs come straight from registers.

module stickman_motion #(
  parameter logic [9:0] Ground_Init = 10'd360,
  parameter logic [9:0] Pit_Y       = 10'd479,
  parameter logic [9:0] Top_Y       = 10'd40,
  parameter logic [7:0] Jump_V      = 8'd12,
  parameter logic [7:0] Gravity     = 8'd1,
  parameter logic [7:0] V_Max       = 8'd15,
  parameter logic [9:0] Step_Max    = 10'd4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       playing,
  input  logic       jump,
  input  logic [9:0] GroundY,
  output logic [9:0] StickmanY,
  output logic       on_ground,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_AIR  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // Frame strobe and jump edge capture
  logic fc_q;
  logic tick_q;
  logic jump_q;
  logic jump_req_q;

  // Motion state
  state_t            state_q;
  logic        [9:0] y_q;
  logic signed [7:0] vy_q;
  logic              on_ground_q;
  logic              game_over_q;

  // Airborne candidate values, computed from the current registers
  logic signed [8:0]  vy_sum;
  logic signed [7:0]  vy_next_d;
  logic signed [10:0] y_sum;
  logic        [9:0]  y_next_d;
  logic               top_hit;
  logic               ground_solid;
  logic               air_wall;
  logic               air_land;
  logic               run_fall;
  logic               run_wall;

  // Frame tick is a one-Clk pulse on the rising edge of frame_clk. A jump
  // press is remembered until the next tick consumes it. A press that lands
  // in the tick cycle itself survives into the following frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_q       <= 1'b0;
      tick_q     <= 1'b0;
      jump_q     <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      fc_q   <= frame_clk;
      tick_q <= frame_clk & ~fc_q;
      jump_q <= jump;
      if (jump && !jump_q) begin
        jump_req_q <= 1'b1;
      end else if (tick_q) begin
        jump_req_q <= 1'b0;
      end else begin
        jump_req_q <= jump_req_q;
      end
    end
  end

  // Gravity step, position step with screen clamp, and collision decisions
  always_comb begin
    vy_sum       = 9'sd0;
    vy_next_d    = 8'sd0;
    y_sum        = 11'sd0;
    y_next_d     = 10'd0;
    top_hit      = 1'b0;
    ground_solid = 1'b0;
    air_wall     = 1'b0;
    air_land     = 1'b0;
    run_fall     = 1'b0;
    run_wall     = 1'b0;

    // Velocity saturates downward at V_Max.
    vy_sum = $signed({vy_q[7], vy_q}) + $signed({Gravity[7], Gravity});
    if (vy_sum > $signed({V_Max[7], V_Max})) begin
      vy_next_d = $signed(V_Max);
    end else begin
      vy_next_d = vy_sum[7:0];
    end

    // Signed 11-bit add so an upward move near the top cannot wrap.
    y_sum = $signed({1'b0, y_q}) + $signed({{3{vy_next_d[7]}}, vy_next_d});
    if (y_sum < $signed({1'b0, Top_Y})) begin
      y_next_d = Top_Y;
      top_hit  = 1'b1;
    end else if (y_sum > $signed({1'b0, Pit_Y})) begin
      y_next_d = Pit_Y;
    end else begin
      y_next_d = y_sum[9:0];
    end

    // A pit column offers nothing to land on or run into.
    ground_solid = (GroundY < Pit_Y);
    air_wall     = ({1'b0, y_q} > ({1'b0, GroundY} + {1'b0, Step_Max})) && ground_solid;
    air_land     = !vy_next_d[7] && (y_next_d >= GroundY) && ground_solid;

    // The wall test only matters once run_fall is false (GroundY <= y_q),
    // so the subtraction cannot underflow when it is used.
    run_fall = (GroundY >= Pit_Y) || (GroundY > y_q);
    run_wall = ((y_q - GroundY) > Step_Max);
  end

  // Run/jump/fall state machine with its registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      y_q         <= Ground_Init;
      vy_q        <= 8'sd0;
      on_ground_q <= 1'b0;
      game_over_q <= 1'b0;
    end else if (!playing) begin
      // Leaving play resets the stickman on every clock, not just on ticks.
      state_q     <= ST_IDLE;
      y_q         <= Ground_Init;
      vy_q        <= 8'sd0;
      on_ground_q <= 1'b0;
      game_over_q <= 1'b0;
    end else if (tick_q) begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_RUN;
          on_ground_q <= 1'b1;
          game_over_q <= 1'b0;
        end
        ST_RUN: begin
          if (jump_req_q) begin
            state_q     <= ST_AIR;
            vy_q        <= $signed(8'd0 - Jump_V);
            on_ground_q <= 1'b0;
          end else if (run_fall) begin
            // Walked off an edge: start falling from rest.
            state_q     <= ST_AIR;
            vy_q        <= 8'sd0;
            on_ground_q <= 1'b0;
          end else if (run_wall) begin
            state_q     <= ST_DEAD;
            on_ground_q <= 1'b0;
            game_over_q <= 1'b1;
          end else begin
            // Small upward steps are walked over by snapping to them.
            y_q <= GroundY;
          end
        end
        ST_AIR: begin
          if (air_wall) begin
            state_q     <= ST_DEAD;
            game_over_q <= 1'b1;
          end else if (air_land) begin
            state_q     <= ST_RUN;
            y_q         <= GroundY;
            vy_q        <= 8'sd0;
            on_ground_q <= 1'b1;
          end else if (y_next_d == Pit_Y) begin
            state_q     <= ST_DEAD;
            y_q         <= Pit_Y;
            game_over_q <= 1'b1;
          end else begin
            y_q <= y_next_d;
            if (top_hit) begin
              vy_q <= 8'sd0;
            end else begin
              vy_q <= vy_next_d;
            end
          end
        end
        ST_DEAD: begin
          // Frozen until play stops or reset.
          state_q <= ST_DEAD;
        end
        default: begin
          state_q     <= ST_IDLE;
          y_q         <= Ground_Init;
          vy_q        <= 8'sd0;
          on_ground_q <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  assign StickmanY = y_q;
  assign on_ground = on_ground_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_stickman_motion.sv
// Scoreboard bench for stickman_motion. Stimulus pushes the hand-computed
// expected {StickmanY, on_ground, game_over} for each frame. Monitors pop and
// compare when the DUT output is due: two Clk after a frame_clk rise, or
// right after an explicit check strobe for reset and play-stop events.

module tb_stickman_motion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       playing;
  logic       jump;
  logic [9:0] GroundY;
  logic [9:0] StickmanY;
  logic       on_ground;
  logic       game_over;

  logic        chk_now = 1'b0;
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Expected feet Y per frame after a jump from flat ground at 360
  int jump_tbl[24] = '{360, 349, 339, 330, 322, 315, 309, 304, 300, 297, 295, 294,
                       294, 295, 297, 300, 304, 309, 315, 322, 330, 339, 349, 360};
  // Expected feet Y per airborne frame when falling from rest at 360
  int fall_tbl[15] = '{361, 363, 366, 370, 375, 381, 388, 396, 405, 415, 426, 438,
                       451, 465, 479};

  stickman_motion dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .playing   (playing),
    .jump      (jump),
    .GroundY   (GroundY),
    .StickmanY (StickmanY),
    .on_ground (on_ground),
    .game_over (game_over)
  );

  always #10 Clk = ~Clk;

  task automatic compare_pop();
    logic [11:0] act;
    logic [11:0] e;
    string       t;
    act = {StickmanY, on_ground, game_over};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_output: got Y=%0d og=%0b go=%0b with no expectation queued",
               act[11:2], act[1], act[0]);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got Y=%0d og=%0b go=%0b, expected Y=%0d og=%0b go=%0b",
                 t, act[11:2], act[1], act[0], e[11:2], e[1], e[0]);
      end
    end
  endtask

  // Frame monitor: outputs settle on the second Clk edge after frame_clk rises
  initial begin
    forever begin
      @(posedge frame_clk);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      compare_pop();
    end
  end

  // Immediate monitor for reset and play-stop checks
  initial begin
    forever begin
      @(posedge chk_now);
      #1;
      compare_pop();
    end
  end

  task automatic push_exp(input logic [9:0] y, input logic og, input logic go, input string tag);
    exp_q.push_back({y, og, go});
    tag_q.push_back(tag);
  endtask

  task automatic frame(input logic [9:0] y, input logic og, input logic go, input string tag);
    push_exp(y, og, go, tag);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic check_now(input logic [9:0] y, input logic og, input logic go, input string tag);
    push_exp(y, og, go, tag);
    chk_now = 1'b1;
    #2;
    chk_now = 1'b0;
  endtask

  task automatic press_jump();
    @(negedge Clk);
    jump = 1'b1;
    repeat (2) @(negedge Clk);
    jump = 1'b0;
    @(negedge Clk);
  endtask

  task automatic stop_play(input string tag);
    @(negedge Clk);
    playing = 1'b0;
    @(negedge Clk);
    check_now(10'd360, 1'b0, 1'b0, tag);
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    playing   = 1'b0;
    jump      = 1'b0;
    GroundY   = 10'd360;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check_now(10'd360, 1'b0, 1'b0, "reset_values");

    // Flat ground
    playing = 1'b1;
    for (int i = 0; i < 3; i++) frame(10'd360, 1'b1, 1'b0, "flat_run");

    // Small step up is walked over
    GroundY = 10'd357;
    frame(10'd357, 1'b1, 1'b0, "step_up");
    stop_play("idle_after_step");
    playing = 1'b1;
    GroundY = 10'd360;
    frame(10'd360, 1'b1, 1'b0, "rerun");

    // Jump arc on flat ground
    press_jump();
    for (int i = 0; i < 24; i++) begin
      frame(10'(jump_tbl[i]), (i == 23) ? 1'b1 : 1'b0, 1'b0, $sformatf("jump_t%0d", i + 1));
    end

    // Step down to 420: fall from rest, land on the 11th airborne frame
    GroundY = 10'd420;
    frame(10'd360, 1'b0, 1'b0, "edge_walk_off");
    for (int i = 0; i < 10; i++) frame(10'(fall_tbl[i]), 1'b0, 1'b0, $sformatf("drop_f%0d", i + 1));
    frame(10'd420, 1'b1, 1'b0, "drop_land");
    stop_play("idle_after_drop");

    // Wall: too tall a step kills, position frozen, jump ignored
    playing = 1'b1;
    GroundY = 10'd360;
    frame(10'd360, 1'b1, 1'b0, "pre_wall_run");
    GroundY = 10'd300;
    frame(10'd360, 1'b0, 1'b1, "wall_dead");
    press_jump();
    GroundY = 10'd360;
    frame(10'd360, 1'b0, 1'b1, "dead_ignores_jump");
    stop_play("idle_after_wall");

    // Pitfall: fall with saturating velocity until feet reach 479
    playing = 1'b1;
    frame(10'd360, 1'b1, 1'b0, "pre_pit_run");
    GroundY = 10'd479;
    frame(10'd360, 1'b0, 1'b0, "pit_enter");
    for (int i = 0; i < 14; i++) frame(10'(fall_tbl[i]), 1'b0, 1'b0, $sformatf("pit_f%0d", i + 1));
    frame(10'd479, 1'b0, 1'b1, "pit_dead");
    frame(10'd479, 1'b0, 1'b1, "pit_dead_hold");
    stop_play("idle_after_pit");

    // Asynchronous reset in the middle of a jump
    playing = 1'b1;
    GroundY = 10'd360;
    frame(10'd360, 1'b1, 1'b0, "pre_reset_run");
    press_jump();
    frame(10'd360, 1'b0, 1'b0, "reset_jump_t1");
    frame(10'd349, 1'b0, 1'b0, "reset_jump_t2");
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_now(10'd360, 1'b0, 1'b0, "async_reset");
    @(negedge Clk);
    Reset = 1'b0;
    frame(10'd360, 1'b1, 1'b0, "run_after_reset");

    repeat (4) @(negedge Clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_expectations: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
